// File: rtl/keypad_entry_if.sv
// Keypad entry port bundle: scanner strobe/code in, decoded entry and event pulses out.
interface keypad_entry_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned CNT_W  = 3
);
  logic                  key_value;
  logic [7:0]            row_col;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic [CNT_W-1:0]      digit_cnt;
  logic [4*DIGITS-1:0]   value_bcd;
  logic [BIN_W-1:0]      value_bin;
  logic                  value_valid;
  logic [1:0]            func_code;
  logic                  func_valid;
  logic                  key_err;
  logic                  busy;

  modport master (
    output key_value, row_col,
    input  disp_bcd, digit_cnt, value_bcd, value_bin, value_valid,
           func_code, func_valid, key_err, busy
  );

  modport slave (
    input  key_value, row_col,
    output disp_bcd, digit_cnt, value_bcd, value_bin, value_valid,
           func_code, func_valid, key_err, busy
  );
endinterface

// File: rtl/keypad_entry.sv
// Decodes 4x4 keypad scanner codes into a BCD entry buffer with edit keys,
// converts the entered value to binary on enter, and forwards function keys.
module keypad_entry #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  keypad_entry_if.slave kp
);
  localparam int unsigned BUF_W = 4 * DIGITS;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_APPLY, S_CONVERT, S_DONE} state_e;
  typedef enum logic [2:0] {K_DIGIT, K_BACK, K_CLEAR, K_ENTER, K_FUNC, K_INV} kclass_e;

  state_e             state_q, state_d;
  kclass_e            kclass_q, kclass_d;
  logic [7:0]         code_q, code_d;
  logic [3:0]         kval_q, kval_d;
  logic [BUF_W-1:0]   disp_q, disp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   vbcd_q, vbcd_d;
  logic [BIN_W-1:0]   vbin_q, vbin_d;
  logic               vvalid_q, vvalid_d;
  logic [1:0]         fcode_q, fcode_d;
  logic               fvalid_q, fvalid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   idx_q, idx_d;

  // Returns {one_cold_ok, position_of_zero} for a scanner nibble.
  function automatic logic [2:0] nib_idx(input logic [3:0] n);
    case (n)
      4'b1110: nib_idx = 3'b100;
      4'b1101: nib_idx = 3'b101;
      4'b1011: nib_idx = 3'b110;
      4'b0111: nib_idx = 3'b111;
      default: nib_idx = 3'b000;
    endcase
  endfunction

  logic [2:0]       row_dec, col_dec;
  logic [1:0]       row_idx, col_idx;
  logic [3:0]       cur_dig;
  logic [BIN_W-1:0] acc_next;

  always_comb begin
    row_dec  = nib_idx(code_q[7:4]);
    col_dec  = nib_idx(code_q[3:0]);
    row_idx  = row_dec[1:0];
    col_idx  = col_dec[1:0];
    cur_dig  = 4'(vbcd_q >> {idx_q, 2'b00});
    acc_next = (acc_q * BIN_W'(10)) + BIN_W'(cur_dig);
  end

  always_comb begin
    state_d  = state_q;
    kclass_d = kclass_q;
    code_d   = code_q;
    kval_d   = kval_q;
    disp_d   = disp_q;
    cnt_d    = cnt_q;
    vbcd_d   = vbcd_q;
    vbin_d   = vbin_q;
    vvalid_d = 1'b0;
    fcode_d  = fcode_q;
    fvalid_d = 1'b0;
    err_d    = 1'b0;
    acc_d    = acc_q;
    idx_d    = idx_q;

    case (state_q)
      S_IDLE: begin
        if (kp.key_value) begin
          code_d  = kp.row_col;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        kval_d  = 4'd0;
        state_d = S_APPLY;
        if (!row_dec[2] || !col_dec[2]) begin
          kclass_d = K_INV;
        end else if (col_idx == 2'd3) begin
          kclass_d = (row_idx == 2'd3) ? K_CLEAR : K_FUNC;
          kval_d   = 4'(row_idx);
        end else if (row_idx == 2'd3) begin
          case (col_idx)
            2'd0:    kclass_d = K_BACK;
            2'd1:    kclass_d = K_DIGIT;
            default: kclass_d = K_ENTER;
          endcase
        end else begin
          kclass_d = K_DIGIT;
          kval_d   = (4'(row_idx) * 4'd3) + 4'(col_idx) + 4'd1;
        end
      end
      S_APPLY: begin
        state_d = S_IDLE;
        case (kclass_q)
          K_DIGIT: begin
            if (cnt_q < CNT_W'(DIGITS)) begin
              disp_d = (disp_q << 4) | BUF_W'(kval_q);
              cnt_d  = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          K_BACK: begin
            if (cnt_q != '0) begin
              disp_d = disp_q >> 4;
              cnt_d  = cnt_q - CNT_W'(1);
            end
          end
          K_CLEAR: begin
            disp_d = '0;
            cnt_d  = '0;
          end
          K_ENTER: begin
            vbcd_d  = disp_q;
            disp_d  = '0;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = CNT_W'(DIGITS - 1);
            state_d = S_CONVERT;
          end
          K_FUNC: begin
            fcode_d  = kval_q[1:0];
            fvalid_d = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
      // MSD first; the last step loads the result so it is on the outputs in DONE.
      S_CONVERT: begin
        acc_d = acc_next;
        if (idx_q == '0) begin
          vbin_d   = acc_next;
          vvalid_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kclass_q <= K_DIGIT;
      code_q   <= '0;
      kval_q   <= '0;
      disp_q   <= '0;
      cnt_q    <= '0;
      vbcd_q   <= '0;
      vbin_q   <= '0;
      vvalid_q <= 1'b0;
      fcode_q  <= '0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      kclass_q <= kclass_d;
      code_q   <= code_d;
      kval_q   <= kval_d;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      vbcd_q   <= vbcd_d;
      vbin_q   <= vbin_d;
      vvalid_q <= vvalid_d;
      fcode_q  <= fcode_d;
      fvalid_q <= fvalid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
  end

  assign kp.disp_bcd    = disp_q;
  assign kp.digit_cnt   = cnt_q;
  assign kp.value_bcd   = vbcd_q;
  assign kp.value_bin   = vbin_q;
  assign kp.value_valid = vvalid_q;
  assign kp.func_code   = fcode_q;
  assign kp.func_valid  = fvalid_q;
  assign kp.key_err     = err_q;
  assign kp.busy        = busy_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: digit entry, edits, enter/convert timing,
// function keys, invalid codes, busy drop and mid-convert reset.
module tb_keypad_entry;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int          n_err, n_func, n_valid, valid_k;
  logic [31:0] bin_v;
  logic        busy_ign;

  keypad_entry_if kp_if ();

  keypad_entry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Strobe one key, then watch 100 cycles; optionally inject a second strobe at cycle T+ign_k.
  task automatic press(input logic [7:0] code, input int ign_k, input logic [7:0] ign_code);
    @(negedge clk);
    kp_if.key_value = 1'b1;
    kp_if.row_col   = code;
    n_err = 0; n_func = 0; n_valid = 0; valid_k = 0; bin_v = '0; busy_ign = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (kp_if.value_valid) begin
        n_valid++;
        valid_k = k;
        bin_v   = 32'(kp_if.value_bin);
      end
      if (kp_if.key_err)    n_err++;
      if (kp_if.func_valid) n_func++;
      if (k == ign_k) begin
        busy_ign        = kp_if.busy;
        kp_if.key_value = 1'b1;
        kp_if.row_col   = ign_code;
      end else begin
        kp_if.key_value = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"},  32'(kp_if.disp_bcd),    32'h0);
    check({tag, "_cnt"},   32'(kp_if.digit_cnt),   32'h0);
    check({tag, "_vbcd"},  32'(kp_if.value_bcd),   32'h0);
    check({tag, "_vbin"},  32'(kp_if.value_bin),   32'h0);
    check({tag, "_valid"}, 32'(kp_if.value_valid), 32'h0);
    check({tag, "_fcode"}, 32'(kp_if.func_code),   32'h0);
    check({tag, "_fval"},  32'(kp_if.func_valid),  32'h0);
    check({tag, "_err"},   32'(kp_if.key_err),     32'h0);
    check({tag, "_busy"},  32'(kp_if.busy),        32'h0);
  endtask

  initial begin
    rst_n           = 1'b0;
    kp_if.key_value = 1'b0;
    kp_if.row_col   = 8'hFF;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 1 2 3 #
    press(8'hEE, 0, 8'h00); check("t1_disp1", 32'(kp_if.disp_bcd), 32'h0001);
    press(8'hED, 0, 8'h00); check("t1_disp12", 32'(kp_if.disp_bcd), 32'h0012);
    press(8'hEB, 0, 8'h00); check("t1_disp123", 32'(kp_if.disp_bcd), 32'h0123);
    check("t1_cnt3", 32'(kp_if.digit_cnt), 32'd3);
    press(8'h7B, 0, 8'h00);
    check("t1_nvalid", 32'(n_valid), 32'd1);
    check("t1_valid_cycle", 32'(valid_k), 32'd7);
    check("t1_bin_at_valid", bin_v, 32'd123);
    check("t1_vbcd", 32'(kp_if.value_bcd), 32'h0123);
    check("t1_vbin", 32'(kp_if.value_bin), 32'd123);
    check("t1_disp_after", 32'(kp_if.disp_bcd), 32'h0);
    check("t1_cnt_after", 32'(kp_if.digit_cnt), 32'd0);

    // 2: 9 8 7 6 5 # (fifth digit overflows)
    press(8'hBB, 0, 8'h00);
    press(8'hBD, 0, 8'h00);
    press(8'hBE, 0, 8'h00);
    press(8'hDB, 0, 8'h00);
    check("t2_disp9876", 32'(kp_if.disp_bcd), 32'h9876);
    check("t2_cnt4", 32'(kp_if.digit_cnt), 32'd4);
    press(8'hDD, 0, 8'h00);
    check("t2_full_err", 32'(n_err), 32'd1);
    check("t2_full_disp", 32'(kp_if.disp_bcd), 32'h9876);
    check("t2_full_cnt", 32'(kp_if.digit_cnt), 32'd4);
    press(8'h7B, 0, 8'h00);
    check("t2_vbin", 32'(kp_if.value_bin), 32'd9876);
    check("t2_vbcd", 32'(kp_if.value_bcd), 32'h9876);
    check("t2_nvalid", 32'(n_valid), 32'd1);

    // 3: 4 5 * * * 2 D
    press(8'hDE, 0, 8'h00); check("t3_disp4", 32'(kp_if.disp_bcd), 32'h0004);
    press(8'hDD, 0, 8'h00); check("t3_disp45", 32'(kp_if.disp_bcd), 32'h0045);
    press(8'h7E, 0, 8'h00); check("t3_bs1", 32'(kp_if.disp_bcd), 32'h0004);
    check("t3_bs1_cnt", 32'(kp_if.digit_cnt), 32'd1);
    press(8'h7E, 0, 8'h00); check("t3_bs2", 32'(kp_if.disp_bcd), 32'h0000);
    press(8'h7E, 0, 8'h00);
    check("t3_bs_empty_err", 32'(n_err), 32'd0);
    check("t3_bs_empty_cnt", 32'(kp_if.digit_cnt), 32'd0);
    press(8'hED, 0, 8'h00); check("t3_disp2", 32'(kp_if.disp_bcd), 32'h0002);
    press(8'h77, 0, 8'h00);
    check("t3_clr_disp", 32'(kp_if.disp_bcd), 32'h0);
    check("t3_clr_cnt", 32'(kp_if.digit_cnt), 32'd0);

    // 4: function keys and invalid codes
    press(8'hE7, 0, 8'h00);
    check("t4_a_nfunc", 32'(n_func), 32'd1);
    check("t4_a_code", 32'(kp_if.func_code), 32'd0);
    press(8'hD7, 0, 8'h00);
    check("t4_b_nfunc", 32'(n_func), 32'd1);
    check("t4_b_code", 32'(kp_if.func_code), 32'd1);
    press(8'hB7, 0, 8'h00);
    check("t4_c_nfunc", 32'(n_func), 32'd1);
    check("t4_c_code", 32'(kp_if.func_code), 32'd2);
    check("t4_c_err", 32'(n_err), 32'd0);
    press(8'hCC, 0, 8'h00);
    check("t4_cc_err", 32'(n_err), 32'd1);
    check("t4_cc_nfunc", 32'(n_func), 32'd0);
    check("t4_cc_code_hold", 32'(kp_if.func_code), 32'd2);
    press(8'h00, 0, 8'h00);
    check("t4_00_err", 32'(n_err), 32'd1);
    check("t4_00_disp", 32'(kp_if.disp_bcd), 32'h0);

    // 5: enter on empty buffer
    press(8'h7B, 0, 8'h00);
    check("t5_nvalid", 32'(n_valid), 32'd1);
    check("t5_bin_at_valid", bin_v, 32'd0);
    check("t5_vbcd", 32'(kp_if.value_bcd), 32'h0);

    // 6a: 3 then #, with a '1' strobe during CONVERT that must be dropped
    press(8'hEB, 0, 8'h00);
    press(8'h7B, 4, 8'hEE);
    check("t6_busy_at_t4", 32'(busy_ign), 32'd1);
    check("t6_nvalid", 32'(n_valid), 32'd1);
    check("t6_valid_cycle", 32'(valid_k), 32'd7);
    check("t6_bin", bin_v, 32'd3);
    check("t6_disp", 32'(kp_if.disp_bcd), 32'h0);
    check("t6_cnt", 32'(kp_if.digit_cnt), 32'd0);
    check("t6_err", 32'(n_err), 32'd0);

    // 6b: 4 2 #, reset asserted in cycle T+4 (mid-CONVERT)
    press(8'hDE, 0, 8'h00);
    press(8'hED, 0, 8'h00);
    @(negedge clk);
    kp_if.key_value = 1'b1;
    kp_if.row_col   = 8'h7B;
    n_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      kp_if.key_value = 1'b0;
      if (kp_if.value_valid) n_valid++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("t6_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (kp_if.value_valid) n_valid++;
    end
    check("t6_rst_nvalid", 32'(n_valid), 32'd0);
    check("t6_rst_vbin", 32'(kp_if.value_bin), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Consumes the 4x4 matrix keypad scanner output (8-bit `row_col` code plus its one-clk `key_value` strobe) and decodes it into key identities. Digit keys accumulate into a DIGITS-wide BCD entry buffer. Edit keys (backspace, clear) modify that buffer. On enter, the block latches the entry, converts it sequentially to binary and emits a one-cycle valid pulse. Function keys A/B/C are passed on as a code plus a one-cycle valid. This block sits between the keypad scanner and the application control/display logic.

Parameters:
- DIGITS, 4: number of BCD digits in the entry buffer (range 1..8).
- BIN_W, 14: width of the binary result; must satisfy 10^DIGITS - 1 < 2^BIN_W.
- CNT_W, 3: width of `digit_cnt`; must satisfy 2^CNT_W > DIGITS.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- key_value, input, 1: one-clk strobe from the scanner; `row_col` is stable while it is high.
- row_col, input, 8: {row[3:0], col[3:0]}; each nibble is active-low one-cold.
- disp_bcd, output, 4*DIGITS: current entry buffer; least significant digit in [3:0].
- digit_cnt, output, CNT_W: number of digits currently entered (0..DIGITS).
- value_bcd, output, 4*DIGITS: entry latched by the last enter.
- value_bin, output, BIN_W: binary equivalent of `value_bcd`.
- value_valid, output, 1: one-cycle pulse; `value_bcd` and `value_bin` are final in that cycle.
- func_code, output, 2: 0 = A, 1 = B, 2 = C.
- func_valid, output, 1: one-cycle pulse accompanying `func_code`.
- key_err, output, 1: one-cycle pulse on an invalid code or on a digit entered while the buffer is full.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs and internal registers go to 0; FSM goes to IDLE.
- All outputs are registered.
- Decode:
  - row_idx is the position of the single 0 in row[3:0]; col_idx is the position of the single 0 in col[3:0].
  - A code is valid only if each nibble has exactly one 0. Any other code, including 8'h00, is invalid.
- Key layout (row_idx, then columns 0..3):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - * = backspace, # = enter, D = clear.
- FSM states: IDLE, DECODE, APPLY, CONVERT, DONE.
  - IDLE: on `key_value`=1 in cycle T, capture `row_col` and go to DECODE.
  - DECODE (cycle T+1): register the key class (digit / backspace / clear / enter / function / invalid) and its value. Go to APPLY.
  - APPLY (cycle T+2): perform the action below. Go to CONVERT if the key was enter, otherwise back to IDLE. Effects are visible on outputs from cycle T+3.
  - CONVERT: DIGITS cycles, most significant digit first, computing acc <= acc*10 + digit, truncated to BIN_W.
  - DONE (cycle T+DIGITS+3): drive `value_bin` = acc and `value_valid` = 1 for exactly that cycle. Return to IDLE.
- Actions in APPLY:
  - Digit, `digit_cnt` < DIGITS: shift the buffer left one digit, insert the new digit at [3:0], increment `digit_cnt`.
  - Digit, `digit_cnt` == DIGITS: buffer unchanged; `key_err` pulses.
  - Backspace: shift the buffer right one digit, zero-fill the top digit, decrement `digit_cnt`. When `digit_cnt` == 0 this is a no-op and `key_err` does not pulse.
  - Clear: buffer = 0, `digit_cnt` = 0.
  - Enter: `value_bcd` <= buffer, then buffer = 0 and `digit_cnt` = 0.
    - Enter with an empty buffer still produces `value_bcd` = 0, `value_bin` = 0 and a `value_valid` pulse.
  - Function key: `func_code` set, `func_valid` pulses. `func_code` holds its value afterwards.
  - Invalid code: `key_err` pulses; nothing else changes.
- Output hold rules: `value_bcd` and `value_bin` hold until the next enter. During CONVERT, `value_bin` keeps its previous value; it updates only in DONE.
- `busy` = (state != IDLE).
- A `key_value` pulse while `busy` is dropped silently: no error, no later effect.
- Reset asserted mid-operation (including mid-CONVERT): immediate return to reset values; no `value_valid` is produced for the aborted entry.

Test Plan:
1. Keys 8'hEE, 8'hED, 8'hEB, then # (8'h7B), spaced 100 clk apart:
   - `disp_bcd` goes 0x0001 -> 0x0012 -> 0x0123.
   - `value_bcd` = 0x0123, `value_bin` = 123.
   - `value_valid` is high exactly in cycle T+7.
   - `disp_bcd` = 0 and `digit_cnt` = 0 afterwards.
2. Keys 9, 8, 7, 6, 5 (8'hBB, BD, BE, DB, DD), then #:
   - After four digits, `disp_bcd` = 0x9876.
   - The fifth digit pulses `key_err` and leaves the buffer unchanged.
   - On #, `value_bin` = 9876.
3. Keys 4, 5, *, *, *, then 2, D:
   - `disp_bcd` goes 0x0004 -> 0x0045 -> 0x0004 -> 0x0000.
   - The third * produces no `key_err`.
   - 2 gives 0x0002; D gives 0 with `digit_cnt` = 0.
4. Keys 8'hE7, D7, B7, then codes 8'hCC and 8'h00:
   - A/B/C give `func_code` 0, 1, 2, each with a one-cycle `func_valid`.
   - 8'hCC and 8'h00 each pulse `key_err` only.
5. # with an empty buffer: `value_valid` pulses with `value_bin` = 0.
6. Busy and reset behaviour:
   - A `key_value` pulse in cycle T+4 of an enter is ignored, and `busy` is high during it.
   - A separate run with `rst_n` low during CONVERT: all outputs are 0 and no `value_valid` ever appears.
